// File: rtl/sc_regshifter_bottomside.sv
// ---------------------------------------------------------------------------
// sc_regshifter_bottomside
// Bottom-row position register. Holds the player's row pattern and moves it
// one bit left/right on active-low commands, refusing moves past the row
// edges. A hold-off counter throttles how often a held button moves the
// pattern. All outputs are registered.
//
// Ports:
//   SC_RegSHIFTERBOTTOM_CLOCK_50          clock, rising edge
//   SC_RegSHIFTERBOTTOM_RESET_InLow       synchronous active-low reset
//   SC_RegSHIFTERBOTTOM_clear_InLow       restore RESET_VALUE (active-low)
//   SC_RegSHIFTERBOTTOM_load_InLow        load data_InBUS (active-low)
//   SC_RegSHIFTERBOTTOM_shiftleft_InLow   move toward MSB (active-low)
//   SC_RegSHIFTERBOTTOM_shiftright_InLow  move toward LSB (active-low)
//   SC_RegSHIFTERBOTTOM_data_InBUS        parallel load value
//   SC_RegSHIFTERBOTTOM_data_OutBUS       registered row pattern
//   SC_RegSHIFTERBOTTOM_moved_OutHigh     pulse: move accepted
//   SC_RegSHIFTERBOTTOM_blocked_OutHigh   pulse: move refused at an edge
//   SC_RegSHIFTERBOTTOM_busy_OutHigh      high during hold-off
// ---------------------------------------------------------------------------
module sc_regshifter_bottomside #(
    parameter int                   DATAWIDTH   = 8,
    parameter logic [DATAWIDTH-1:0] RESET_VALUE = 8'b00001000,
    parameter int                   HOLDOFF     = 4
) (
    input  logic                 SC_RegSHIFTERBOTTOM_CLOCK_50,
    input  logic                 SC_RegSHIFTERBOTTOM_RESET_InLow,
    input  logic                 SC_RegSHIFTERBOTTOM_clear_InLow,
    input  logic                 SC_RegSHIFTERBOTTOM_load_InLow,
    input  logic                 SC_RegSHIFTERBOTTOM_shiftleft_InLow,
    input  logic                 SC_RegSHIFTERBOTTOM_shiftright_InLow,
    input  logic [DATAWIDTH-1:0] SC_RegSHIFTERBOTTOM_data_InBUS,
    output logic [DATAWIDTH-1:0] SC_RegSHIFTERBOTTOM_data_OutBUS,
    output logic                 SC_RegSHIFTERBOTTOM_moved_OutHigh,
    output logic                 SC_RegSHIFTERBOTTOM_blocked_OutHigh,
    output logic                 SC_RegSHIFTERBOTTOM_busy_OutHigh
);

    localparam int CW = $clog2(HOLDOFF) + 1;
    localparam logic [CW-1:0] CNT_START = CW'(HOLDOFF - 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATAWIDTH-1:0]  data_q, data_d;
    logic                  moved_q, moved_d;
    logic                  blocked_q, blocked_d;
    logic                  busy_q, busy_d;

    logic req_left, req_right, at_edge;

    // Exactly one direction asserted forms a request; both or neither is none.
    assign req_left  = !SC_RegSHIFTERBOTTOM_shiftleft_InLow &&  SC_RegSHIFTERBOTTOM_shiftright_InLow;
    assign req_right =  SC_RegSHIFTERBOTTOM_shiftleft_InLow && !SC_RegSHIFTERBOTTOM_shiftright_InLow;
    // Edge checks look only at the end bits, so arbitrary loaded patterns
    // (including all-zero) are handled without a one-hot check.
    assign at_edge   = (req_left && data_q[DATAWIDTH-1]) || (req_right && data_q[0]);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        moved_d   = 1'b0;
        blocked_d = 1'b0;
        busy_d    = 1'b0;
        if (!SC_RegSHIFTERBOTTOM_clear_InLow) begin
            // Clear and load abort any hold-off in progress.
            data_d  = RESET_VALUE;
            state_d = IDLE;
            cnt_d   = '0;
        end else if (!SC_RegSHIFTERBOTTOM_load_InLow) begin
            data_d  = SC_RegSHIFTERBOTTOM_data_InBUS;
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_left || req_right) begin
                        if (at_edge) begin
                            blocked_d = 1'b1;
                        end else begin
                            data_d  = req_left ? (data_q << 1) : (data_q >> 1);
                            moved_d = 1'b1;
                            // HOLDOFF of 1 means no hold-off: a held button
                            // moves every cycle straight from IDLE.
                            if (HOLDOFF > 1) begin
                                state_d = HOLD;
                                cnt_d   = CNT_START;
                                busy_d  = 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    // Counter values HOLDOFF-1 .. 1 each cost one busy cycle.
                    if (cnt_q <= 1) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d  = cnt_q - 1'b1;
                        busy_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge SC_RegSHIFTERBOTTOM_CLOCK_50) begin
        if (!SC_RegSHIFTERBOTTOM_RESET_InLow) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_q    <= RESET_VALUE;
            moved_q   <= 1'b0;
            blocked_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            moved_q   <= moved_d;
            blocked_q <= blocked_d;
            busy_q    <= busy_d;
        end
    end

    assign SC_RegSHIFTERBOTTOM_data_OutBUS     = data_q;
    assign SC_RegSHIFTERBOTTOM_moved_OutHigh   = moved_q;
    assign SC_RegSHIFTERBOTTOM_blocked_OutHigh = blocked_q;
    assign SC_RegSHIFTERBOTTOM_busy_OutHigh    = busy_q;

endmodule

// File: tb/tb_sc_regshifter_bottomside.sv
// ---------------------------------------------------------------------------
// tb_sc_regshifter_bottomside
// Scoreboard bench: the driver applies one command per cycle, predicts the
// registered outputs with a behavioural model and queues them; the monitor
// pops one entry after every rising edge and compares.
// ---------------------------------------------------------------------------
module tb_sc_regshifter_bottomside;

    localparam int        W       = 8;
    localparam int        HOLDOFF = 4;
    localparam logic [7:0] RV     = 8'b00001000;

    typedef struct packed {
        logic [W-1:0] data;
        logic         moved;
        logic         blocked;
        logic         busy;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0, clr_n = 1'b1, ld_n = 1'b1, sl_n = 1'b1, sr_n = 1'b1;
    logic [W-1:0] din = '0;
    logic [W-1:0] dout;
    logic         moved, blocked, busy;

    sc_regshifter_bottomside #(.DATAWIDTH(W), .RESET_VALUE(RV), .HOLDOFF(HOLDOFF)) dut (
        .SC_RegSHIFTERBOTTOM_CLOCK_50        (clk),
        .SC_RegSHIFTERBOTTOM_RESET_InLow     (rst_n),
        .SC_RegSHIFTERBOTTOM_clear_InLow     (clr_n),
        .SC_RegSHIFTERBOTTOM_load_InLow      (ld_n),
        .SC_RegSHIFTERBOTTOM_shiftleft_InLow (sl_n),
        .SC_RegSHIFTERBOTTOM_shiftright_InLow(sr_n),
        .SC_RegSHIFTERBOTTOM_data_InBUS      (din),
        .SC_RegSHIFTERBOTTOM_data_OutBUS     (dout),
        .SC_RegSHIFTERBOTTOM_moved_OutHigh   (moved),
        .SC_RegSHIFTERBOTTOM_blocked_OutHigh (blocked),
        .SC_RegSHIFTERBOTTOM_busy_OutHigh    (busy)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   drv_done = 1'b0;

    // Reference model: pattern plus "busy cycles still to run".
    logic [W-1:0] m_data = RV;
    int           m_wait = 0;

    task automatic step(input logic r, input logic c, input logic l,
                        input logic sl, input logic sr, input logic [W-1:0] d);
        exp_t e;
        @(negedge clk);
        rst_n = r; clr_n = c; ld_n = l; sl_n = sl; sr_n = sr; din = d;
        e = '0;
        if (!r) begin
            m_data = RV; m_wait = 0;
        end else if (!c) begin
            m_data = RV; m_wait = 0;
        end else if (!l) begin
            m_data = d; m_wait = 0;
        end else if (m_wait > 0) begin
            m_wait = m_wait - 1;          // commands ignored while holding off
        end else if (sl != sr) begin
            if (!sl) begin
                if (m_data[W-1]) e.blocked = 1'b1;
                else begin m_data = m_data * 2; e.moved = 1'b1; m_wait = HOLDOFF - 1; end
            end else begin
                if (m_data[0]) e.blocked = 1'b1;
                else begin m_data = m_data / 2; e.moved = 1'b1; m_wait = HOLDOFF - 1; end
            end
        end
        e.data = m_data;
        e.busy = (m_wait > 0);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 1, 1, 1, 8'h00);
    endtask

    // Monitor: one expected entry per rising edge that followed a command.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (dout !== e.data) begin
                    bad++; $display("FAIL data: got %b expected %b at %0t", dout, e.data, $time);
                end
                total++;
                if (moved !== e.moved) begin
                    bad++; $display("FAIL moved: got %b expected %b at %0t", moved, e.moved, $time);
                end
                total++;
                if (blocked !== e.blocked) begin
                    bad++; $display("FAIL blocked: got %b expected %b at %0t", blocked, e.blocked, $time);
                end
                total++;
                if (busy !== e.busy) begin
                    bad++; $display("FAIL busy: got %b expected %b at %0t", busy, e.busy, $time);
                end
            end
        end
    end

    initial begin
        int guard;
        // Reset for two cycles, then quiet.
        step(0, 1, 1, 1, 1, 8'h00);
        step(0, 1, 1, 1, 1, 8'h00);
        idle(2);
        // Single left move with hold-off, then settle.
        step(1, 1, 1, 0, 1, 8'h00);
        idle(4);
        // Restore and hold right until the edge, then blocked every cycle.
        step(1, 0, 1, 1, 1, 8'h00);
        for (int i = 0; i < 14; i++) step(1, 1, 1, 1, 0, 8'h00);
        // Left edge.
        step(1, 1, 0, 1, 1, 8'h80);
        step(1, 1, 1, 0, 1, 8'h00);
        step(1, 1, 1, 0, 1, 8'h00);
        // Both directions: no request. Clear wins over load.
        step(1, 1, 1, 0, 0, 8'h00);
        step(1, 0, 0, 1, 1, 8'hF0);
        // Load aborts hold-off; an immediate move is accepted.
        step(1, 1, 1, 0, 1, 8'h00);
        step(1, 1, 0, 1, 1, 8'h01);
        step(1, 1, 1, 0, 1, 8'h00);
        // Reset mid hold-off.
        step(1, 1, 1, 1, 1, 8'h00);
        step(0, 1, 1, 0, 1, 8'h00);
        idle(1);
        // All-zero pattern never blocks and stays zero.
        step(1, 1, 0, 1, 1, 8'h00);
        for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 1, 8'h00);
        // Multi-bit pattern shifts as-is.
        step(1, 1, 0, 1, 1, 8'h5A);
        for (int i = 0; i < 9; i++) step(1, 1, 1, 1, 0, 8'h00);
        // Random traffic, biased toward moves.
        for (int i = 0; i < 3000; i++) begin
            logic r, c, l, sl, sr;
            r  = ($urandom_range(0, 99) >= 2);
            c  = ($urandom_range(0, 99) >= 3);
            l  = ($urandom_range(0, 99) >= 5);
            sl = ($urandom_range(0, 99) >= 45);
            sr = ($urandom_range(0, 99) >= 45);
            step(r, c, l, sl, sr, W'($urandom));
        end
        drv_done = 1'b1;
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sc_regshifter_bottomside.md
Name: sc_regshifter_bottomside

Overview:
- Registered 8-bit bottom-row position register, one stage upstream of the bottom-side right comparator.
- Holds the player's one-hot row pattern and moves it left or right on active-low move commands.
- Moves stop at the row edges, and a hold-off counter limits how often a held button can move the pattern.
- Its data output bus drives the comparator's data input directly, together with status pulses to the game control FSM.

Parameters:
- DATAWIDTH, 8, row width in bits.
- RESET_VALUE, 8'b00001000, row pattern loaded on reset and on clear.
- HOLDOFF, 4, cycles from one accepted move to the next accepted move; legal range is 1 or more.

Ports:
- SC_RegSHIFTERBOTTOM_CLOCK_50  input  1  system clock, rising edge.
- SC_RegSHIFTERBOTTOM_RESET_InLow  input  1  synchronous active-low reset.
- SC_RegSHIFTERBOTTOM_clear_InLow  input  1  active-low; restore RESET_VALUE.
- SC_RegSHIFTERBOTTOM_load_InLow  input  1  active-low; load data_InBUS.
- SC_RegSHIFTERBOTTOM_shiftleft_InLow  input  1  active-low; move one bit toward the MSB.
- SC_RegSHIFTERBOTTOM_shiftright_InLow  input  1  active-low; move one bit toward the LSB.
- SC_RegSHIFTERBOTTOM_data_InBUS  input  DATAWIDTH  parallel load value.
- SC_RegSHIFTERBOTTOM_data_OutBUS  output  DATAWIDTH  registered row pattern, feeds the comparator.
- SC_RegSHIFTERBOTTOM_moved_OutHigh  output  1  one-cycle pulse when a move is accepted.
- SC_RegSHIFTERBOTTOM_blocked_OutHigh  output  1  one-cycle pulse when a move is refused at an edge.
- SC_RegSHIFTERBOTTOM_busy_OutHigh  output  1  high while in hold-off.

Behaviour:
- Clocking and reset
  - One clock. Reset is synchronous and active-low, sampled on the rising edge of CLOCK_50.
  - Reset values: data_OutBUS = RESET_VALUE; moved, blocked and busy = 0; FSM in IDLE; counter = 0.
  - Reset overrides every other input, including when it arrives mid hold-off.
- Priority per cycle: reset > clear > load > move.
  - Clear or load takes effect on the next edge.
  - Either one aborts any hold-off: FSM goes to IDLE, counter to 0, no moved/blocked pulse that cycle.
- Move request
  - A request exists when exactly one of shiftleft_InLow / shiftright_InLow is 0.
  - Both asserted together, or neither asserted, means no request.
- FSM state IDLE, with a request:
  - Left with data[DATAWIDTH-1]=1, or right with data[0]=1: data unchanged, blocked=1 next cycle, stay in IDLE.
  - Otherwise: data shifts logically by one bit with zero fill, moved=1 next cycle.
  - If HOLDOFF>1: go to HOLD with counter = HOLDOFF-1 and busy=1.
  - If HOLDOFF=1: stay in IDLE, so a held button moves the pattern every cycle.
- FSM state HOLD:
  - Move requests are ignored, with no blocked pulse.
  - Counter decrements by 1 each cycle.
  - When the counter reaches 1, next state is IDLE and busy=0 in IDLE.
  - An accepted move is therefore followed by exactly HOLDOFF-1 busy cycles.
- Timing and auto-repeat
  - All outputs are registered; latency from command to data_OutBUS is 1 cycle.
  - moved/blocked are single-cycle pulses, never asserted together.
  - A button held continuously repeats its move every HOLDOFF cycles until an edge is reached, then gives a blocked pulse every cycle.
- Load value
  - Loaded data is not checked for one-hot; a multi-bit pattern shifts as-is.
  - Edge checks use only the MSB and LSB.
  - An all-zero pattern never blocks and stays zero.
- Counter width is clog2(HOLDOFF)+1 bits; no wrap-around is possible.

Test Plan:
- Reset: RESET_InLow=0 for 2 cycles, then release -> data_OutBUS=8'b00001000, moved=0, blocked=0, busy=0.
- Single move: from 00001000, shiftleft_InLow=0 for 1 cycle -> next cycle data=00010000 (comparator output goes high), moved=1, busy=1 for 3 cycles.
- Held button: shiftright_InLow=0 held from 00001000 with HOLDOFF=4 -> data 00000100 at t+1, 00000010 at t+5, 00000001 at t+9, then blocked=1 every cycle with data unchanged.
- Edge: load 10000000, then shiftleft_InLow=0 -> data unchanged, blocked=1, moved=0, busy=0.
- Conflicts: both shift inputs=0 -> no change, no pulses; clear_InLow=0 and load_InLow=0 together with data_InBUS=8'hF0 -> data=00001000.
- Abort: during hold-off (busy=1), load_InLow=0 with 8'h01 -> data=00000001, busy=0 next cycle; an immediate shiftleft is accepted -> 00000010. Reset asserted mid hold-off -> RESET_VALUE, busy=0.
